// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type for the banked SRAM controller.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        DP_NONE,
        DP_READ,
        DP_WRITE,
        DP_ERR1,
        DP_ERR2
    } dp_state_e;

    // Byte lanes touched by a transfer of the given size at the given byte offset.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << offs;
            HSIZE_HALF: lanes = offs[1] ? 4'b1100 : 4'b0011;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted-write buffer: captures the write address phase, takes the data
// at the end of the data phase, commits to SRAM in the next free port cycle and
// merges its pending bytes into reads of the same word.
module ahb_sram_wbuf
    import ahb_pkg::*;
#(
    parameter int AW = 10,
    parameter int BW = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          aph_we_i,
    input  logic [BW-1:0] aph_bank_i,
    input  logic [AW-1:0] aph_word_i,
    input  logic [3:0]    aph_lanes_i,
    input  logic          load_i,
    input  logic [31:0]   wdata_i,
    input  logic          rd_aph_i,
    input  logic [BW-1:0] rd_bank_i,
    input  logic [AW-1:0] rd_word_i,
    input  logic [31:0]   rd_raw_i,
    output logic [31:0]   rd_merged_o,
    output logic          commit_o,
    output logic [BW-1:0] wb_bank_o,
    output logic [AW-1:0] wb_word_o,
    output logic [3:0]    wb_lanes_o,
    output logic [31:0]   wb_data_o
);

    // Address of the write currently in its data phase (not yet in the buffer).
    logic [BW-1:0] pa_bank_q, pa_bank_d;
    logic [AW-1:0] pa_word_q, pa_word_d;
    logic [3:0]    pa_lanes_q, pa_lanes_d;

    logic          wb_valid_q, wb_valid_d;
    logic [BW-1:0] wb_bank_q, wb_bank_d;
    logic [AW-1:0] wb_word_q, wb_word_d;
    logic [3:0]    wb_lanes_q, wb_lanes_d;
    logic [31:0]   wb_data_q, wb_data_d;

    logic hit;

    // A read address phase owns the SRAM port; otherwise a valid entry drains.
    assign commit_o   = wb_valid_q & ~rd_aph_i;
    assign wb_bank_o  = wb_bank_q;
    assign wb_word_o  = wb_word_q;
    assign wb_lanes_o = wb_lanes_q;
    assign wb_data_o  = wb_data_q;

    // Next state: capture write address, then load the entry when its data arrives.
    always_comb begin
        pa_bank_d  = pa_bank_q;
        pa_word_d  = pa_word_q;
        pa_lanes_d = pa_lanes_q;
        wb_valid_d = wb_valid_q & ~commit_o;
        wb_bank_d  = wb_bank_q;
        wb_word_d  = wb_word_q;
        wb_lanes_d = wb_lanes_q;
        wb_data_d  = wb_data_q;
        if (aph_we_i) begin
            pa_bank_d  = aph_bank_i;
            pa_word_d  = aph_word_i;
            pa_lanes_d = aph_lanes_i;
        end
        // A load in the same cycle as a commit leaves the new entry in place.
        if (load_i) begin
            wb_valid_d = 1'b1;
            wb_bank_d  = pa_bank_q;
            wb_word_d  = pa_word_q;
            wb_lanes_d = pa_lanes_q;
            wb_data_d  = wdata_i;
        end
    end

    // Control and address registers; reset discards any pending write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pa_bank_q  <= '0;
            pa_word_q  <= '0;
            pa_lanes_q <= '0;
            wb_valid_q <= 1'b0;
            wb_bank_q  <= '0;
            wb_word_q  <= '0;
            wb_lanes_q <= '0;
        end else begin
            pa_bank_q  <= pa_bank_d;
            pa_word_q  <= pa_word_d;
            pa_lanes_q <= pa_lanes_d;
            wb_valid_q <= wb_valid_d;
            wb_bank_q  <= wb_bank_d;
            wb_word_q  <= wb_word_d;
            wb_lanes_q <= wb_lanes_d;
        end
    end

    // Buffered write data.
    // NOTE: data-only storage has no reset; it is never observed unless wb_valid_q is set.
    always_ff @(posedge clk_i) begin
        wb_data_q <= wb_data_d;
    end

    // Overlay pending bytes onto SRAM read data when the read hits the buffered word.
    always_comb begin
        hit         = wb_valid_q && (wb_bank_q == rd_bank_i) && (wb_word_q == rd_word_i);
        rd_merged_o = rd_raw_i;
        for (int i = 0; i < 4; i++) begin
            if (hit && wb_lanes_q[i]) begin
                rd_merged_o[8*i +: 8] = wb_data_q[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_sram_banked_ctrl.sv
// AHB-Lite slave over NBANKS single-port SRAM banks: address decode, data-phase
// FSM with two-cycle ERROR response, registered bank mux and posted writes.
module ahb_sram_banked_ctrl
    import ahb_pkg::*;
#(
    parameter int NBANKS = 3,
    parameter int AW     = 10
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [NBANKS-1:0]     SRAM_EN,
    output logic [3:0]            SRAM_WE,
    output logic [AW-1:0]         SRAM_A,
    output logic [31:0]           SRAM_DI,
    input  logic [NBANKS*32-1:0]  SRAM_DO
);

    localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam logic [BW:0] NBANKS_L = NBANKS[BW:0];

    dp_state_e state_q, state_d;
    logic [BW-1:0] rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_word_q, rd_word_d;

    logic [BW-1:0] aph_bank;
    logic [AW-1:0] aph_word;
    logic [3:0]    aph_lanes;
    logic          accept, illegal, rd_aph, wr_aph;
    logic [31:0]   rd_raw, rd_merged;
    logic          commit;
    logic [BW-1:0] wb_bank;
    logic [AW-1:0] wb_word;
    logic [3:0]    wb_lanes;
    logic [31:0]   wb_data;
    logic          unused_in;

    // Upper address bits alias onto the populated range; HTRANS[0] only separates SEQ/NONSEQ.
    assign unused_in = ^{HADDR[31:AW+BW+2], HTRANS[0]};

    assign aph_bank  = HADDR[AW+BW+1:AW+2];
    assign aph_word  = HADDR[AW+1:2];
    assign aph_lanes = byte_lanes(HSIZE, HADDR[1:0]);
    // Held reset also blocks the address-phase SRAM access so every output sits idle.
    assign accept    = HSEL & HREADY & HTRANS[1] & HRESETn;
    assign illegal   = (HSIZE > HSIZE_WORD) | ({1'b0, aph_bank} >= NBANKS_L);
    assign rd_aph    = accept & ~HWRITE & ~illegal;
    assign wr_aph    = accept & HWRITE & ~illegal;

    ahb_sram_wbuf #(
        .AW (AW),
        .BW (BW)
    ) u_wbuf (
        .clk_i       (HCLK),
        .rst_ni      (HRESETn),
        .aph_we_i    (wr_aph),
        .aph_bank_i  (aph_bank),
        .aph_word_i  (aph_word),
        .aph_lanes_i (aph_lanes),
        .load_i      (state_q == DP_WRITE),
        .wdata_i     (HWDATA),
        .rd_aph_i    (rd_aph),
        .rd_bank_i   (rd_bank_q),
        .rd_word_i   (rd_word_q),
        .rd_raw_i    (rd_raw),
        .rd_merged_o (rd_merged),
        .commit_o    (commit),
        .wb_bank_o   (wb_bank),
        .wb_word_o   (wb_word),
        .wb_lanes_o  (wb_lanes),
        .wb_data_o   (wb_data)
    );

    // Next data-phase state and bus response outputs.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = DP_NONE;
        rd_bank_d = rd_bank_q;
        rd_word_d = rd_word_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        if (state_q == DP_ERR1) begin
            state_d = DP_ERR2;
        end else if (accept) begin
            if (illegal)     state_d = DP_ERR1;
            else if (HWRITE) state_d = DP_WRITE;
            else             state_d = DP_READ;
        end
        if (rd_aph) begin
            rd_bank_d = aph_bank;
            rd_word_d = aph_word;
        end
        case (state_q)
            DP_READ: HRDATA = rd_merged;
            DP_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            DP_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // Data-phase state and registered read address.
    // NOTE: sequential state uses <= so all registers update together from pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= DP_NONE;
            rd_bank_q <= '0;
            rd_word_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_word_q <= rd_word_d;
        end
    end

    // Read-data mux driven by the registered bank, so it settles before the data phase.
    always_comb begin
        rd_raw = '0;
        for (int k = 0; k < NBANKS; k++) begin
            if (rd_bank_q == BW'(k)) rd_raw = SRAM_DO[32*k +: 32];
        end
    end

    // SRAM port arbitration: an address-phase read wins, otherwise the buffer drains.
    always_comb begin
        SRAM_EN = '0;
        SRAM_WE = '0;
        SRAM_A  = '0;
        SRAM_DI = '0;
        if (rd_aph) begin
            SRAM_EN[aph_bank] = 1'b1;
            SRAM_A            = aph_word;
        end else if (commit) begin
            SRAM_EN[wb_bank] = 1'b1;
            SRAM_WE          = wb_lanes;
            SRAM_A           = wb_word;
            SRAM_DI          = wb_data;
        end
    end

endmodule

// File: doc/ahb_sram_banked_ctrl.md
Name: ahb_sram_banked_ctrl

Overview:
- Parametrised AHB-Lite slave that fronts NBANKS single-port, 1-cycle-read SRAM macros with 32-bit words and 4 byte-enables.
- Replaces the ad-hoc chip-select logic and combinational read-data mux used for the SoC SRAM.
- Adds zero-wait-state writes through a one-entry write buffer, read-after-write byte merging, and an ERROR response for unpopulated banks and illegal sizes.

Parameters:
- NBANKS, 3: number of SRAM banks (1..8).
- AW, 10: word-address bits per bank (bank depth is 2^AW words).

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  write/read.
- HSIZE  in  3  transfer size.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- SRAM_EN  out  NBANKS  per-bank enable (one-hot or zero).
- SRAM_WE  out  4  byte write enables.
- SRAM_A  out  AW  word address within bank.
- SRAM_DI  out  32  write data to SRAM.
- SRAM_DO  in  NBANKS*32  read data, bank k at bits [32k+31:32k].

Behaviour:
- Clock and reset: one clock, HCLK. Reset is asynchronous and active-low on HRESETn.
- Accepted transfer: HSEL & HREADY & HTRANS[1]. IDLE/BUSY or unselected transfers get a zero-wait OKAY and never read the SRAM.
- Address decode:
  - BW = clog2(NBANKS), minimum 1.
  - bank = HADDR[AW+BW+1:AW+2]; word = HADDR[AW+1:2].
  - HADDR bits above AW+BW+1 are ignored (aliasing).
- Byte lanes:
  - byte: one lane, selected by HADDR[1:0].
  - half: lanes {1,0} or {3,2}, selected by HADDR[1].
  - word: all four lanes.
- Illegal transfers: HSIZE > 2, or bank >= NBANKS. These cause no SRAM access and give the ERROR response below.
- Data-phase FSM, states DP_NONE, DP_READ, DP_WRITE, DP_ERR1, DP_ERR2:
  - An accepted legal read goes to DP_READ; an accepted legal write goes to DP_WRITE; an accepted illegal transfer goes to DP_ERR1.
  - DP_ERR1 always goes to DP_ERR2.
  - DP_ERR2 and every other state: next state is decided by the next accepted transfer, otherwise DP_NONE.
  - HREADYOUT=0 only in DP_ERR1. HRESP=1 in DP_ERR1 and DP_ERR2. Every legal transfer is zero-wait OKAY.
- Read path:
  - The SRAM is accessed combinationally in the address phase: SRAM_EN[bank]=1, SRAM_WE=0, SRAM_A=word.
  - Bank and word are registered. In DP_READ, HRDATA = SRAM_DO slice of the registered bank.
  - HRDATA=0 outside DP_READ.
- Write buffer (wb_valid, wb_bank, wb_word, wb_lanes, wb_data):
  - The write address phase registers bank, word and lanes.
  - At the clock edge ending DP_WRITE, HWDATA is loaded into wb_data and wb_valid is set to 1.
  - Commit: in any cycle with wb_valid=1 and no accepted legal read address phase, drive SRAM_EN[wb_bank]=1, SRAM_WE=wb_lanes, SRAM_A=wb_word, SRAM_DI=wb_data, then clear wb_valid.
  - If a new write data phase loads the buffer in the same cycle as a commit, the buffer holds the new entry.
  - A read address phase always has priority over a commit.
  - Invariant: at most one buffered write. A write address phase cycle always commits any older entry. The bench asserts that the buffer is never loaded while it is valid and not committing.
- Read-after-write merge: in DP_READ, if wb_valid and {wb_bank,wb_word} equals the registered read address, each HRDATA byte lane set in wb_lanes comes from wb_data.
- Back-to-back write then read of the same word:
  - The read address phase coincides with the write data phase.
  - The buffer loads at that edge, and the merge applies in the read data phase.
  - HRDATA returns the new data with zero wait.
- Reset (asynchronous) values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, SRAM_EN=0, SRAM_WE=0, SRAM_A=0, SRAM_DI=0.
  - FSM in DP_NONE, wb_valid=0.
- Reset mid-operation: a pending buffered write is discarded. An in-flight ERROR sequence is aborted.

Decomposition:
- Package ahb_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, HRESP_OKAY/HRESP_ERROR, and the dp_state enum.
- Sub-module ahb_sram_wbuf: the write-buffer registers, commit request/grant, address compare and byte-lane merge.
- The top level owns decode, the FSM and the bank mux.

Test Plan:
- Word write 0x0000_0010 = 0xDEADBEEF, then IDLE, then read 0x10 → SRAM write on bank0 word 4 with WE=4'hF; read returns 0xDEADBEEF; HREADYOUT stays 1 throughout.
- Back-to-back: byte write 0xAA to 0x1003 over old 0x11223344, with the read of 0x1000 in the very next cycle → HRDATA=0xAA223344 with zero wait; SRAM write occurs after the read's address phase.
- Continuous reads on every cycle after a write to bank2 (NBANKS=3, address 0x2000+) → commit deferred until the first non-read cycle; a later read of that word returns the written data.
- Read of 0x3000 (bank 3 with NBANKS=3) → cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1; SRAM_EN never asserted.
- HSIZE=3 write → same two-cycle ERROR; buffer unchanged.
- Halfword write 0xBEEF to 0x0006, reset asserted before the commit, then release and read 0x0004 → read returns the pre-write SRAM contents; all outputs at reset values while HRESETn=0.
